// File: rtl/pc_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_pkg
//  Description : Shared definitions for the instruction-fetch unit: datapath
//                width, reset PC, NOP encoding, FSM state encoding and the
//                branch-offset helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_fetch_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    // Word offset -> byte offset: sign-extend and scale by 4.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_if
//  Description : Instruction-memory read bus between the fetch unit (master)
//                and the instruction memory (slave).
//  Signals     : imem_req   - read request, master -> slave
//                imem_addr  - word-aligned read address, master -> slave
//                imem_rdata - instruction word, slave -> master
//                imem_ack   - completion strobe, slave -> master
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_if
    import pc_fetch_pkg::*;
;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );

endinterface
`default_nettype wire

// File: rtl/pc_fetch_npc.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_npc
//  Description : Combinational next-PC selection. Priority: jump, then taken
//                branch, then sequential pc+4. All arithmetic wraps mod 2^32.
//  Ports       : pc_i           - current PC
//                jump_i         - instruction is a jump
//                jump_target_i  - 26-bit instr_index of the jump
//                branch_taken_i - instruction is a taken branch
//                branch_imm_i   - signed branch offset in words
//                next_pc_o      - selected next PC
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_npc
    import pc_fetch_pkg::*;
(
    input  wire logic [XLEN-1:0] pc_i,
    input  wire logic            jump_i,
    input  wire logic [25:0]     jump_target_i,
    input  wire logic            branch_taken_i,
    input  wire logic [15:0]     branch_imm_i,
    output logic      [XLEN-1:0] next_pc_o
);

    logic [XLEN-1:0] w_pc_plus4;

    assign w_pc_plus4 = pc_i + 32'd4;

    always_comb begin
        next_pc_o = w_pc_plus4;
        if (jump_i) begin
            // Jump stays inside the 256 MB region of the delay-slot address.
            next_pc_o = {w_pc_plus4[31:28], jump_target_i, 2'b00};
        end else if (branch_taken_i) begin
            next_pc_o = w_pc_plus4 + branch_offset(branch_imm_i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch
//  Description : Instruction-fetch unit. Issues a read at pc, captures the
//                returned word, holds it for the decoder until accepted, then
//                advances pc (sequential / branch / jump) and counts accepts.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                imem (master)       - instruction-memory read bus
//                instr_o             - held instruction word
//                instr_valid_o       - instr_o is fetched and unconsumed
//                instr_ready_i       - decoder accepts instr_o this cycle
//                jump_i/jump_target_i, branch_taken_i/branch_imm_i
//                                    - control flow of the accepted instruction
//                halt_i              - block starting new fetches
//                pc_o                - address of fetched / held instruction
//                instr_count_o       - accepted-instruction counter
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
)(
    input  wire logic            clk,
    input  wire logic            rst_n,
    pc_fetch_if.master           imem,
    output logic      [XLEN-1:0] instr_o,
    output logic                 instr_valid_o,
    input  wire logic            instr_ready_i,
    input  wire logic            jump_i,
    input  wire logic [25:0]     jump_target_i,
    input  wire logic            branch_taken_i,
    input  wire logic [15:0]     branch_imm_i,
    input  wire logic            halt_i,
    output logic      [XLEN-1:0] pc_o,
    output logic      [XLEN-1:0] instr_count_o
);

    // Low bits forced to zero so pc stays word-aligned even if the
    // parameter is overridden with an unaligned value.
    localparam logic [31:0] C_PC_RESET = {PC_RESET[31:2], 2'b00};

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] count_q;
    logic            req_q;
    logic            valid_q;

    logic [XLEN-1:0] next_pc_d;
    logic [XLEN-1:0] count_d;

    pc_fetch_npc u_npc (
        .pc_i           (pc_q),
        .jump_i         (jump_i),
        .jump_target_i  (jump_target_i),
        .branch_taken_i (branch_taken_i),
        .branch_imm_i   (branch_imm_i),
        .next_pc_o      (next_pc_d)
    );

    assign count_d = count_q + 32'd1;

    // Single-process FSM; imem_req and instr_valid are registered alongside
    // the state so they change exactly on the state transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= C_PC_RESET;
            instr_q <= NOP_INSTR;
            count_q <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!halt_i) begin
                        state_q <= ST_FETCH;
                        req_q   <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    // halt is deliberately not looked at: a started fetch completes.
                    if (imem.imem_ack) begin
                        instr_q <= imem.imem_rdata;
                        valid_q <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // imem_ack here is stray and ignored.
                    if (instr_ready_i) begin
                        pc_q    <= next_pc_d;
                        count_q <= count_d;
                        valid_q <= 1'b0;
                        if (halt_i) begin
                            state_q <= ST_IDLE;
                            req_q   <= 1'b0;
                        end else begin
                            state_q <= ST_FETCH;
                            req_q   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign instr_o        = instr_q;
    assign instr_valid_o  = valid_q;
    assign pc_o           = pc_q;
    assign instr_count_o  = count_q;

endmodule
`default_nettype wire

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter PC_RESET, default 32'h0000_3000, address of the first instruction fetched after reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  word-aligned fetch address, equal to pc.
REQ-006 imem_rdata  input  32  instruction word, valid in the cycle imem_ack=1.
REQ-007 imem_ack  input  1  memory completion strobe.
REQ-008 instr  output  32  held instruction word for the decoder (OpCode=instr[31:26], funct=instr[5:0]).
REQ-009 instr_valid  output  1  instr holds a fetched, unconsumed instruction.
REQ-010 instr_ready  input  1  decoder/execute accepts instr this cycle.
REQ-011 jump  input  1  accepted instruction is a jump.
REQ-012 jump_target  input  26  instr_index field of the jump.
REQ-013 branch_taken  input  1  accepted instruction is a branch whose condition holds.
REQ-014 branch_imm  input  16  signed branch offset in words.
REQ-015 halt  input  1  suppress new fetches while high.
REQ-016 pc  output  32  address of the instruction currently fetched or held.
REQ-017 instr_count  output  32  number of instructions accepted since reset.

Function
REQ-018 FSM states are IDLE, FETCH and HOLD; reset enters IDLE.
REQ-019 IDLE: outputs imem_req=0 and instr_valid=0; moves to FETCH on the next edge when halt=0, otherwise stays in IDLE.
REQ-020 FETCH: imem_req=1 and imem_addr=pc, held until imem_ack=1; on ack, imem_rdata is captured into instr and the FSM moves to HOLD.
REQ-021 Fetch latency: instr_valid rises on the edge that samples imem_ack=1; minimum 1 cycle from entering FETCH.
REQ-022 HOLD: instr_valid=1 and instr is stable until instr_ready=1 is sampled (accept).
REQ-023 On accept, pc is loaded with the next PC, instr_count increments, and the FSM moves to FETCH when halt=0 or to IDLE when halt=1.
REQ-024 Next PC is selected by priority, using pc_plus4 = pc+4:
  - jump: {pc_plus4[31:28], jump_target, 2'b00}.
  - else branch_taken: pc_plus4 + (sign-extended branch_imm << 2).
  - else: pc_plus4.
REQ-025 jump and branch_taken are sampled only in the accept cycle; when both are high, jump wins.
REQ-026 All PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0, and negative offsets wrap the same way.
REQ-027 pc[1:0] is always 2'b00.
REQ-028 imem_ack outside FETCH is ignored; instr and pc are unchanged.
REQ-029 halt never aborts an outstanding FETCH and never drops a held instruction; it only blocks leaving IDLE or HOLD into FETCH.
REQ-030 instr_count wraps from 32'hFFFF_FFFF to 0.

Reset
REQ-031 Asserting rst_n=0 at any time, including mid-FETCH, immediately forces:
  - state=IDLE, pc=PC_RESET, instr=32'h0000_0000, instr_count=0;
  - imem_req=0, instr_valid=0.
REQ-032 A pending imem_ack during or after reset is discarded.
REQ-033 The first fetch after reset release is issued at PC_RESET.

Structure
REQ-034 A shared package holds the FSM state encoding, PC_RESET_DEFAULT, and NOP_INSTR (32'h0).
REQ-035 Next-PC selection is a combinational sub-module npc: inputs pc, jump, jump_target, branch_taken, branch_imm; output next_pc.

Verification
REQ-036 Reset, then ack after 2 cycles with rdata=32'h2008_0005; assert ready -> imem_addr=32'h0000_3000, instr_valid rises on the ack edge, next addr=32'h0000_3004, instr_count=1.
REQ-037 Accept with branch_taken=1, branch_imm=16'hFFFF at pc=32'h0000_3008 -> next pc=32'h0000_3008; with imm=16'h0003 -> next pc=32'h0000_3018.
REQ-038 Accept with jump=1, branch_taken=1, jump_target=26'h000_0C10 at pc=32'h0000_3010 -> next pc=32'h0000_3040 (jump priority).
REQ-039 Hold instr_ready=0 for 5 cycles -> instr, pc and instr_valid stable, imem_req=0; then ready=1 -> one accept, count+1.
REQ-040 rst_n=0 mid-FETCH with ack pulsed the same cycle -> imem_req=0 and instr_valid=0 immediately, pc=32'h0000_3000, no instruction captured.
REQ-041 halt=1 during FETCH -> the fetch completes and is accepted, then the FSM sits in IDLE with imem_req=0; halt=0 -> FETCH resumes at the next PC.
